// File: rtl/uart_bus_pkg.sv
// Shared constants for the UART command-frame decoder:
// sync byte, error codes and the frame state encoding.
package uart_bus_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_BAD_CMD = 2'b01;
    localparam logic [1:0] ERR_CHKSUM  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_DATA,
        ST_CHK,
        ST_ISSUE
    } state_e;

endpackage

// File: rtl/uart_rx_frame_decoder.sv
// Decodes SYNC/CMD/ADDR_H/ADDR_L/DATA/CHK byte frames from a UART
// receiver into a registered valid/ready bus command.
module uart_rx_frame_decoder
    import uart_bus_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_write,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic                  busy
);

    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CLKS - 1);
    localparam logic [DATA_WIDTH-1:0] SYNC = DATA_WIDTH'(SYNC_BYTE);

    state_e                state_q, state_d;
    logic                  rx_ready_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
    logic                  frm_write_q, frm_write_d;
    logic [ADDR_WIDTH-1:0] frm_addr_q, frm_addr_d;
    logic [DATA_WIDTH-1:0] frm_data_q, frm_data_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic                  strobe;
    logic                  in_frame;

    assign strobe   = rx_ready & ~rx_ready_q;
    assign in_frame = (state_q != ST_IDLE) && (state_q != ST_ISSUE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        frm_write_d = frm_write_q;
        frm_addr_d  = frm_addr_q;
        frm_data_d  = frm_data_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        err_d       = 1'b0;
        code_d      = ERR_OVERRUN;

        // Inter-byte timeout; a strobe on the expiry cycle takes priority.
        if (in_frame) begin
            if (strobe) begin
                cnt_d = '0;
            end else if (cnt_q == TO_MAX) begin
                cnt_d   = '0;
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (strobe && rx_data == SYNC) begin
                    chk_d   = '0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (strobe) begin
                    if (rx_data[DATA_WIDTH-1:1] == '0) begin
                        frm_write_d = rx_data[0];
                        chk_d       = chk_q ^ rx_data;
                        state_d     = ST_ADDR_H;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_BAD_CMD;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ADDR_H, ST_ADDR_L: begin
                if (strobe) begin
                    frm_addr_d = {frm_addr_q[ADDR_WIDTH-DATA_WIDTH-1:0], rx_data};
                    chk_d      = chk_q ^ rx_data;
                    state_d    = (state_q == ST_ADDR_H) ? ST_ADDR_L : ST_DATA;
                end
            end
            ST_DATA: begin
                if (strobe) begin
                    frm_data_d = rx_data;
                    chk_d      = chk_q ^ rx_data;
                    state_d    = ST_CHK;
                end
            end
            ST_CHK: begin
                if (strobe) begin
                    if (rx_data == chk_q) begin
                        cmd_valid_d = 1'b1;
                        cmd_write_d = frm_write_q;
                        cmd_addr_d  = frm_addr_q;
                        cmd_wdata_d = frm_data_q;
                        state_d     = ST_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHKSUM;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    // Handshake frees us; a coincident byte is an IDLE byte.
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    if (strobe && rx_data == SYNC) begin
                        chk_d   = '0;
                        state_d = ST_CMD;
                    end
                end else if (strobe) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rx_ready_q  <= 1'b0;
            cnt_q       <= '0;
            chk_q       <= '0;
            frm_write_q <= 1'b0;
            frm_addr_q  <= '0;
            frm_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            err_q       <= 1'b0;
            code_q      <= ERR_OVERRUN;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            frm_write_q <= frm_write_d;
            frm_addr_q  <= frm_addr_d;
            frm_data_q  <= frm_data_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;
    assign frame_err = err_q;
    assign err_code  = code_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Directed bench for uart_rx_frame_decoder: decode, handshake,
// error codes, timeout edge, overrun and reset abandon.
module tb_uart_rx_frame_decoder;

    localparam int T = 16;

    logic        clk;
    logic        rst;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    int total;
    int bad;
    int pulses;

    uart_rx_frame_decoder #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(16),
        .TIMEOUT_CLKS(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .frame_err(frame_err),
        .err_code(err_code),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err) pulses++;

    // Called at a negedge; one low cycle, then one strobe edge.
    // Returns at the negedge just after the strobe edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] ah,
                              input logic [7:0] al, input logic [7:0] d,
                              input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(ah);
        send_byte(al);
        send_byte(d);
        send_byte(k);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({cmd_valid, frame_err, err_code, busy, cmd_write} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=000000",
                     {cmd_valid, frame_err, err_code, busy, cmd_write});
        end
        total++;
        if ({cmd_addr, cmd_wdata} !== 24'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=000000", {cmd_addr, cmd_wdata});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_hold;
        cmd_ready = 1'b0;
        send_frame(8'h01, 8'h12, 8'h34, 8'h5A, 8'h7D);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({cmd_valid, cmd_write, cmd_addr, cmd_wdata, busy} !==
                {1'b1, 1'b1, 16'h1234, 8'h5A, 1'b1}) begin
                bad++;
                $display("FAIL write_hold[%0d] got v=%b w=%b a=%h d=%h b=%b exp 1 1 1234 5a 1",
                         i, cmd_valid, cmd_write, cmd_addr, cmd_wdata, busy);
            end
            if (i < 3) @(negedge clk);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        total++;
        if ({cmd_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL write_clear got v=%b b=%b exp 0 0", cmd_valid, busy);
        end
    endtask

    task automatic test_read;
        cmd_ready = 1'b1;
        send_frame(8'h00, 8'h00, 8'h10, 8'h00, 8'h10);
        total++;
        if ({cmd_valid, cmd_write, cmd_addr} !== {1'b1, 1'b0, 16'h0010}) begin
            bad++;
            $display("FAIL read_cmd got v=%b w=%b a=%h exp 1 0 0010",
                     cmd_valid, cmd_write, cmd_addr);
        end
        @(negedge clk);
        total++;
        if (cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_one_cycle got v=%b exp 0", cmd_valid);
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_bad_cmd;
        int p0;
        p0 = pulses;
        send_byte(8'h3C);
        @(negedge clk);
        total++;
        if ({busy, frame_err, pulses} !== {1'b0, 1'b0, p0}) begin
            bad++;
            $display("FAIL ignore_3c got b=%b e=%b pulses=%0d exp 0 0 %0d",
                     busy, frame_err, pulses, p0);
        end
        send_byte(8'hA5);
        send_byte(8'h81);
        total++;
        if ({frame_err, err_code, busy} !== {1'b1, 2'b01, 1'b0}) begin
            bad++;
            $display("FAIL bad_cmd got e=%b c=%b b=%b exp 1 01 0",
                     frame_err, err_code, busy);
        end
        @(negedge clk);
        total++;
        if (frame_err !== 1'b0) begin
            bad++;
            $display("FAIL err_one_cycle got e=%b exp 0", frame_err);
        end
    endtask

    task automatic test_bad_chk;
        cmd_ready = 1'b0;
        send_frame(8'h01, 8'h12, 8'h34, 8'h5A, 8'h7C);
        total++;
        if ({frame_err, err_code, cmd_valid, busy} !== {1'b1, 2'b10, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL bad_chk got e=%b c=%b v=%b b=%b exp 1 10 0 0",
                     frame_err, err_code, cmd_valid, busy);
        end
        cmd_ready = 1'b1;
        send_frame(8'h00, 8'h00, 8'h10, 8'h00, 8'h10);
        total++;
        if ({cmd_valid, cmd_write, cmd_addr} !== {1'b1, 1'b0, 16'h0010}) begin
            bad++;
            $display("FAIL after_chk got v=%b w=%b a=%h exp 1 0 0010",
                     cmd_valid, cmd_write, cmd_addr);
        end
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic test_timeout;
        int p0;
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (T - 1) @(negedge clk);
        total++;
        if ({frame_err, busy} !== 2'b01) begin
            bad++;
            $display("FAIL to_early got e=%b b=%b exp 0 1", frame_err, busy);
        end
        @(negedge clk);
        total++;
        if ({frame_err, err_code, busy} !== {1'b1, 2'b11, 1'b0}) begin
            bad++;
            $display("FAIL timeout got e=%b c=%b b=%b exp 1 11 0",
                     frame_err, err_code, busy);
        end
        @(negedge clk);
        p0 = pulses;
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (T - 2) @(negedge clk);
        send_byte(8'h12);
        total++;
        if ({frame_err, busy} !== 2'b01) begin
            bad++;
            $display("FAIL strobe_wins got e=%b b=%b exp 0 1", frame_err, busy);
        end
        cmd_ready = 1'b1;
        send_byte(8'h34);
        send_byte(8'h5A);
        send_byte(8'h7D);
        total++;
        if ({cmd_valid, cmd_addr, cmd_wdata} !== {1'b1, 16'h1234, 8'h5A}) begin
            bad++;
            $display("FAIL to_frame got v=%b a=%h d=%h exp 1 1234 5a",
                     cmd_valid, cmd_addr, cmd_wdata);
        end
        @(negedge clk);
        cmd_ready = 1'b0;
        @(negedge clk);
        total++;
        if (pulses !== p0) begin
            bad++;
            $display("FAIL to_no_pulse got pulses=%0d exp %0d", pulses, p0);
        end
    endtask

    task automatic test_overrun;
        int p0;
        cmd_ready = 1'b0;
        send_frame(8'h01, 8'h12, 8'h34, 8'h5A, 8'h7D);
        send_byte(8'hA5);
        total++;
        if ({frame_err, err_code} !== {1'b1, 2'b00}) begin
            bad++;
            $display("FAIL overrun got e=%b c=%b exp 1 00", frame_err, err_code);
        end
        total++;
        if ({cmd_valid, cmd_write, cmd_addr, cmd_wdata, busy} !==
            {1'b1, 1'b1, 16'h1234, 8'h5A, 1'b1}) begin
            bad++;
            $display("FAIL overrun_hold got v=%b w=%b a=%h d=%h b=%b exp 1 1 1234 5a 1",
                     cmd_valid, cmd_write, cmd_addr, cmd_wdata, busy);
        end
        @(negedge clk);
        p0 = pulses;
        rx_data   = 8'hA5;
        rx_ready  = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clk);
        rx_ready  = 1'b0;
        cmd_ready = 1'b0;
        total++;
        if ({cmd_valid, busy, frame_err} !== 3'b010) begin
            bad++;
            $display("FAIL back_to_back got v=%b b=%b e=%b exp 0 1 0",
                     cmd_valid, busy, frame_err);
        end
        cmd_ready = 1'b1;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h10);
        total++;
        if ({cmd_valid, cmd_write, cmd_addr} !== {1'b1, 1'b0, 16'h0010}) begin
            bad++;
            $display("FAIL b2b_frame got v=%b w=%b a=%h exp 1 0 0010",
                     cmd_valid, cmd_write, cmd_addr);
        end
        @(negedge clk);
        cmd_ready = 1'b0;
        @(negedge clk);
        total++;
        if (pulses !== p0) begin
            bad++;
            $display("FAIL b2b_no_pulse got pulses=%0d exp %0d", pulses, p0);
        end
    endtask

    task automatic test_reset_mid;
        int p0;
        p0 = pulses;
        cmd_ready = 1'b0;
        send_frame(8'h01, 8'h12, 8'h34, 8'h5A, 8'h7D);
        rst = 1'b1;
        #1;
        total++;
        if ({cmd_valid, busy, frame_err, cmd_addr, cmd_wdata} !== 27'h0) begin
            bad++;
            $display("FAIL rst_issue got v=%b b=%b e=%b a=%h d=%h exp all 0",
                     cmd_valid, busy, frame_err, cmd_addr, cmd_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        rst = 1'b1;
        #1;
        total++;
        if ({cmd_valid, busy, frame_err, err_code} !== 5'b0) begin
            bad++;
            $display("FAIL rst_mid got v=%b b=%b e=%b c=%b exp all 0",
                     cmd_valid, busy, frame_err, err_code);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (T + 4) @(negedge clk);
        total++;
        if ({pulses, busy} !== {p0, 1'b0}) begin
            bad++;
            $display("FAIL rst_no_pulse got pulses=%0d b=%b exp %0d 0",
                     pulses, busy, p0);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        pulses    = 0;
        rst       = 1'b1;
        rx_ready  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
        test_reset();
        test_write_hold();
        test_read();
        test_bad_cmd();
        test_bad_chk();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
